// File: rtl/req_debounce_latch_debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_bit
//  Purpose  : One request channel: 2-flop synchroniser, saturating debounce
//             counter, accepted (stable) level and registered rising pulse.
//  Revision : 1.0
// ============================================================================
module debounce_bit #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_in,
    output logic stable,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYC - 1);

    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;
    logic             r_rise;

    logic             w_differ;
    logic             w_accept;

    assign w_differ = (r_s2 != r_stable);
    assign w_accept = w_differ && (r_cnt == c_cnt_max);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
        end else begin
            r_s1   <= sw_in;
            r_s2   <= r_s1;
            // Pulse lands in the same cycle the new stable level becomes visible.
            r_rise <= w_accept & r_s2;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign stable = r_stable;
    assign rise   = r_rise;

endmodule
`default_nettype wire

// File: rtl/req_debounce_latch.sv
`default_nettype none
// ============================================================================
//  Module   : req_debounce_latch
//  Purpose  : Debounced switch request front-end with optional sticky latch
//             feeding the priority encoder (req) and its enable (any_req).
//  Revision : 1.0
// ============================================================================
module req_debounce_latch #(
    parameter int WIDTH        = 8,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    input  logic             sticky_en,
    input  logic             clr,
    output logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] rise,
    output logic             any_req
);

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] r_lat;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
            debounce_bit #(
                .DEBOUNCE_CYC (DEBOUNCE_CYC)
            ) u_debounce_bit (
                .clk    (clk),
                .rst    (rst),
                .sw_in  (sw_in[gi]),
                .stable (w_stable[gi]),
                .rise   (rise[gi])
            );
        end
    endgenerate

    // Set dominates clear so a flick arriving with clr is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lat <= '0;
        end else begin
            r_lat <= (clr ? '0 : r_lat) | rise;
        end
    end

    assign req     = sticky_en ? r_lat : w_stable;
    assign any_req = |req;

endmodule
`default_nettype wire

// File: tb/tb_req_debounce_latch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_req_debounce_latch
//  Purpose  : Vector-table and scoreboard bench for req_debounce_latch.
//  Revision : 1.0
// ============================================================================
module tb_req_debounce_latch;

    localparam int WIDTH        = 8;
    localparam int DEBOUNCE_CYC = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] sw_in;
    logic             sticky_en;
    logic             clr;
    logic [WIDTH-1:0] req;
    logic [WIDTH-1:0] rise;
    logic             any_req;

    req_debounce_latch #(
        .WIDTH        (WIDTH),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .sw_in     (sw_in),
        .sticky_en (sticky_en),
        .clr       (clr),
        .req       (req),
        .rise      (rise),
        .any_req   (any_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] sw;
        logic       sticky;
        logic       clr;
        logic [7:0] req;
        logic [7:0] rise;
        logic       any;
    } vec_t;

    typedef struct {
        logic [7:0] req;
        logic [7:0] rise;
        logic       any;
        int         tag;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   tag   = 0;

    task automatic add(input logic r, input logic [7:0] s, input logic st, input logic c,
                       input logic [7:0] er, input logic [7:0] ei, input logic ea);
        vec_t v;
        v.rst = r; v.sw = s; v.sticky = st; v.clr = c;
        v.req = er; v.rise = ei; v.any = ea;
        vecs.push_back(v);
    endtask

    task automatic check_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: got no entry, want one");
            return;
        end
        e = exp_q.pop_front();
        total += 3;
        if (req !== e.req) begin
            bad++;
            $display("FAIL req step %0d: got %h want %h", e.tag, req, e.req);
        end
        if (rise !== e.rise) begin
            bad++;
            $display("FAIL rise step %0d: got %h want %h", e.tag, rise, e.rise);
        end
        if (any_req !== e.any) begin
            bad++;
            $display("FAIL any_req step %0d: got %b want %b", e.tag, any_req, e.any);
        end
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        rst       = v.rst;
        sw_in     = v.sw;
        sticky_en = v.sticky;
        clr       = v.clr;
        e.req  = v.req;
        e.rise = v.rise;
        e.any  = v.any;
        e.tag  = tag;
        exp_q.push_back(e);
        tag++;
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic run_one(input logic r, input logic [7:0] s, input logic st, input logic c,
                           input logic [7:0] er, input logic [7:0] ei, input logic ea);
        vec_t v;
        v.rst = r; v.sw = s; v.sticky = st; v.clr = c;
        v.req = er; v.rise = ei; v.any = ea;
        step(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; sw_in = '0; sticky_en = 1'b0; clr = 1'b0;

        // Reset with all switches high, then first cycle out of reset.
        add(1, 8'hFF, 0, 0, 8'h00, 8'h00, 0);
        add(1, 8'hFF, 0, 0, 8'h00, 8'h00, 0);
        add(0, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        // Clean step on ch2: accepted at the 6th edge, then released.
        for (int i = 0; i < 5; i++) add(0, 8'h04, 0, 0, 8'h00, 8'h00, 0);
        add(0, 8'h04, 0, 0, 8'h04, 8'h04, 1);
        add(0, 8'h04, 0, 0, 8'h04, 8'h00, 1);
        for (int i = 0; i < 5; i++) add(0, 8'h00, 0, 0, 8'h04, 8'h00, 1);
        add(0, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        // Three-cycle glitch on ch7 is rejected.
        for (int i = 0; i < 3; i++) add(0, 8'h80, 0, 0, 8'h00, 8'h00, 0);
        for (int i = 0; i < 5; i++) add(0, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        // Sticky: clear stale latch, latch ch4, release switch, then clear.
        add(0, 8'h00, 1, 1, 8'h00, 8'h00, 0);
        for (int i = 0; i < 5; i++) add(0, 8'h10, 1, 0, 8'h00, 8'h00, 0);
        add(0, 8'h10, 1, 0, 8'h00, 8'h10, 0);
        for (int i = 0; i < 6; i++) add(0, 8'h00, 1, 0, 8'h10, 8'h00, 1);
        add(0, 8'h00, 1, 1, 8'h00, 8'h00, 0);
        add(0, 8'h00, 1, 0, 8'h00, 8'h00, 0);
        // Sticky: clr coincident with ch0 rise while ch5 latched.
        add(0, 8'h20, 1, 0, 8'h00, 8'h00, 0);
        for (int i = 0; i < 4; i++) add(0, 8'h21, 1, 0, 8'h00, 8'h00, 0);
        add(0, 8'h21, 1, 0, 8'h00, 8'h20, 0);
        add(0, 8'h21, 1, 0, 8'h20, 8'h01, 1);
        add(0, 8'h21, 1, 1, 8'h01, 8'h00, 1);
        add(0, 8'h21, 1, 0, 8'h01, 8'h00, 1);
        // Dropping sticky_en shows debounced levels immediately.
        add(0, 8'h21, 0, 0, 8'h21, 8'h00, 1);

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // Reset in the middle of a ch0 count discards the partial count.
        run_one(1, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        for (int i = 0; i < 4; i++) run_one(0, 8'h01, 0, 0, 8'h00, 8'h00, 0);
        run_one(1, 8'h01, 0, 0, 8'h00, 8'h00, 0);
        for (int i = 0; i < 5; i++) run_one(0, 8'h01, 0, 0, 8'h00, 8'h00, 0);
        run_one(0, 8'h01, 0, 0, 8'h01, 8'h01, 1);
        run_one(0, 8'h01, 0, 0, 8'h01, 8'h00, 1);

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover: got %0d entries, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
